alu_issue: RTL
==============

# alu_issue

Execute-issue stage that drives the 32-bit ALU. It decodes an RV32I instruction word plus its register-file read data into the ALU's `SrcA`, `SrcB` and 4-bit `Operation` inputs and holds them in a valid/ready pipeline register between decode and execute. It sits in the decode/execute (ID/EX) boundary; its outputs connect directly to the ALU inputs.

## Interface
- `DATA_WIDTH`, 32, operand and register data width
- `OPCODE_LENGTH`, 4, width of `Operation`
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream has an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  RV32I instruction word
- `in_rs1_data`  in  DATA_WIDTH  rs1 register value
- `in_rs2_data`  in  DATA_WIDTH  rs2 register value
- `flush`  in  1  synchronous kill of all held entries
- `out_valid`  out  1  `SrcA`/`SrcB`/`Operation` valid toward execute
- `out_ready`  in  1  execute consumes this cycle
- `SrcA`, `SrcB`  out  DATA_WIDTH  ALU operands
- `Operation`  out  OPCODE_LENGTH  ALU op code
- `out_illegal`  out  1  instruction not supported by the ALU

## Operation
- Transfer in on `in_valid && in_ready`; transfer out on `out_valid && out_ready`. Order strictly preserved; no loss, no duplication.
- R-type (`0110011`): funct3 `000` → ADD `0010` (funct7[5]=0) / SUB `0110` (=1); `001` SLL `0011`; `010` SLT `1100`; `100` XOR `0100`; `101` SRL `0101` / SRA `1010` by funct7[5]; `110` OR `0001`; `111` AND `0000`. `SrcA`=rs1, `SrcB`=rs2.
- I-type ALU (`0010011`): same map except funct3 `000` is always ADD; `SrcB` = sign-extended `instr[31:20]`. Shift type selected by `instr[30]`.
- Load (`0000011`): ADD, `SrcB` = I-immediate. Store (`0100011`): ADD, `SrcB` = sign-extended `{instr[31:25],instr[11:7]}`.
- Branch (`1100011`): funct3 `000` EQ `1000`, `001` NE `1001`, `100` SLT `1100`, `101` GE `1101`; `SrcB`=rs2.
- LUI (`0110111`): ADD, `SrcA`=0, `SrcB`=`{instr[31:12],12'b0}`.
- Anything else (incl. SLTU/SLTIU, BLTU/BGEU, other opcodes): `out_illegal`=1, `Operation`=`1111`, `SrcA`=`SrcB`=0. Still passes through the handshake as a normal entry.
- Decode is combinational on input; results are captured in the register on acceptance.

## Timing
- Reset (async assert, sync-safe release): `out_valid`=0, `SrcA`=`SrcB`=0, `Operation`=`1111`, `out_illegal`=0, `in_ready`=1.
- Latency: instruction accepted in cycle N is presented with `out_valid`=1 in cycle N+1.
- Full throughput: with `out_ready` held 1, one instruction per cycle.
- Outputs stable while `out_valid && !out_ready`.
- `flush`: next cycle all entries invalid, `out_valid`=0, `in_ready`=1; an instruction offered in the flush cycle is dropped. Flush has priority over all transfers.
- Reset mid-stream discards every entry immediately.

## Configuration
- `ALU_ISSUE_SKID_EN` defined: two entries (output register + skid register); `in_ready` driven from a flop (= skid empty). An accept while output stalled goes to skid; `in_ready` falls the following cycle; skid moves to output when output drains.
- Undefined: single output register; `in_ready` = `!out_valid || out_ready` (combinational path from `out_ready`). Capacity one.

## Test plan
- Reset then `add x3,x1,x2` (`0x002081B3`), rs1=5, rs2=7 → next cycle `out_valid`=1, `Operation`=`0010`, `SrcA`=5, `SrcB`=7.
- `srai x5,x6,4` (`0x40435293`), rs1=`0x80000000` → `Operation`=`1010`, `SrcB`=`0x00000404`, `SrcA`=`0x80000000`.
- `sw x2,-4(x1)` (`0xFE20AE23`), rs1=`0x100` → `Operation`=`0010`, `SrcB`=`0xFFFFFFFC`.
- `out_ready`=0, three back-to-back instructions → with `_EN` two accepted then `in_ready`=0 (without: one); release `out_ready` → outputs emerge in original order, none lost.
- Two entries held, pulse `flush` → next cycle `out_valid`=0, `in_ready`=1; subsequent `bge` (funct3 `101`) issues `Operation`=`1101`.
- `sltu` (`0x0020B1B3`) → `out_illegal`=1, `Operation`=`1111`, `SrcA`=`SrcB`=0; next legal instruction clears `out_illegal`.

Source files
------------

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Execute-issue stage in front of the 32-bit ALU. Decodes an
//               RV32I instruction word and its register-file read data into
//               SrcA / SrcB / Operation and holds them in a valid/ready
//               pipeline register between decode and execute.
//
// Ports       : clk, reset (async, active-high)
//               in_valid / in_ready     upstream handshake
//               in_instr, in_rs1_data, in_rs2_data   instruction + operands
//               flush                   synchronous kill of held entries
//               out_valid / out_ready   downstream handshake
//               SrcA, SrcB, Operation   ALU inputs
//               out_illegal             instruction not executable by ALU
//
// Options     : ALU_ISSUE_SKID_EN - adds a skid register so in_ready comes
//               from a flop; otherwise a single register whose in_ready is
//               combinational from out_ready.
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [DATA_WIDTH-1:0]    in_rs1_data,
    input  logic [DATA_WIDTH-1:0]    in_rs2_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_illegal
);

    localparam logic [OPCODE_LENGTH-1:0] c_OP_AND = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_OR  = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_ADD = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLL = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_XOR = 4'b0100;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRL = 4'b0101;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SUB = 4'b0110;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_EQ  = 4'b1000;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_NE  = 4'b1001;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRA = 4'b1010;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLT = 4'b1100;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_GE  = 4'b1101;
    localparam logic [OPCODE_LENGTH-1:0] c_OP_ILL = 4'b1111;

    localparam logic [6:0] c_OPC_R      = 7'b0110011;
    localparam logic [6:0] c_OPC_I      = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;

    // Shared R-type / I-type funct3 map; alt selects SUB / SRA.
    function automatic logic [OPCODE_LENGTH-1:0] f_alu_op(input logic [2:0] f3,
                                                          input logic       alt);
        logic [OPCODE_LENGTH-1:0] op;
        case (f3)
            3'b000:  op = alt ? c_OP_SUB : c_OP_ADD;
            3'b001:  op = c_OP_SLL;
            3'b010:  op = c_OP_SLT;
            3'b100:  op = c_OP_XOR;
            3'b101:  op = alt ? c_OP_SRA : c_OP_SRL;
            3'b110:  op = c_OP_OR;
            3'b111:  op = c_OP_AND;
            default: op = c_OP_ILL;   // SLTU / SLTIU
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [6:0]               w_opc;
    logic [2:0]               w_f3;
    logic [DATA_WIDTH-1:0]    w_imm_i;
    logic [DATA_WIDTH-1:0]    w_imm_s;
    logic [DATA_WIDTH-1:0]    w_imm_u;
    logic [DATA_WIDTH-1:0]    w_a;
    logic [DATA_WIDTH-1:0]    w_b;
    logic [OPCODE_LENGTH-1:0] w_op;
    logic                     w_ill;

    assign w_opc   = in_instr[6:0];
    assign w_f3    = in_instr[14:12];
    assign w_imm_i = DATA_WIDTH'($signed(in_instr[31:20]));
    assign w_imm_s = DATA_WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
    assign w_imm_u = DATA_WIDTH'({in_instr[31:12], 12'b0});

    always_comb begin
        w_a   = in_rs1_data;
        w_b   = in_rs2_data;
        w_op  = c_OP_ILL;
        case (w_opc)
            c_OPC_R:     w_op = f_alu_op(w_f3, in_instr[30]);
            c_OPC_I: begin
                // Immediate ADD has no SUB form; instr[30] only matters for shifts.
                w_op = f_alu_op(w_f3, (w_f3 == 3'b101) && in_instr[30]);
                w_b  = w_imm_i;
            end
            c_OPC_LOAD: begin
                w_op = c_OP_ADD;
                w_b  = w_imm_i;
            end
            c_OPC_STORE: begin
                w_op = c_OP_ADD;
                w_b  = w_imm_s;
            end
            c_OPC_BRANCH: begin
                case (w_f3)
                    3'b000:  w_op = c_OP_EQ;
                    3'b001:  w_op = c_OP_NE;
                    3'b100:  w_op = c_OP_SLT;
                    3'b101:  w_op = c_OP_GE;
                    default: w_op = c_OP_ILL;  // BLTU / BGEU
                endcase
            end
            c_OPC_LUI: begin
                w_op = c_OP_ADD;
                w_a  = '0;
                w_b  = w_imm_u;
            end
            default:     w_op = c_OP_ILL;
        endcase
        // Anything the ALU cannot execute carries zero operands.
        w_ill = (w_op == c_OP_ILL);
        if (w_ill) begin
            w_a = '0;
            w_b = '0;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline storage
    // ------------------------------------------------------------------
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_out_a;
    logic [DATA_WIDTH-1:0]    r_out_b;
    logic [OPCODE_LENGTH-1:0] r_out_op;
    logic                     r_out_ill;
    logic                     w_accept;

    assign w_accept = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
    logic                     r_skid_valid;
    logic [DATA_WIDTH-1:0]    r_skid_a;
    logic [DATA_WIDTH-1:0]    r_skid_b;
    logic [OPCODE_LENGTH-1:0] r_skid_op;
    logic                     r_skid_ill;

    // Skid is only ever occupied behind a full output register, so an empty
    // skid means there is room for one more entry regardless of out_ready.
    assign in_ready = !r_skid_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_op     <= c_OP_ILL;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_op    <= c_OP_ILL;
            r_skid_ill   <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                // in_ready is low here, so no new accept competes with the skid.
                r_out_valid  <= 1'b1;
                r_out_a      <= r_skid_a;
                r_out_b      <= r_skid_b;
                r_out_op     <= r_skid_op;
                r_out_ill    <= r_skid_ill;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_a   <= w_a;
                    r_out_b   <= w_b;
                    r_out_op  <= w_op;
                    r_out_ill <= w_ill;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_a     <= w_a;
            r_skid_b     <= w_b;
            r_skid_op    <= w_op;
            r_skid_ill   <= w_ill;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_op    <= c_OP_ILL;
            r_out_ill   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (in_ready) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_a   <= w_a;
                r_out_b   <= w_b;
                r_out_op  <= w_op;
                r_out_ill <= w_ill;
            end
        end
    end
`endif

    assign out_valid   = r_out_valid;
    assign SrcA        = r_out_a;
    assign SrcB        = r_out_b;
    assign Operation   = r_out_op;
    assign out_illegal = r_out_ill;

endmodule
`default_nettype wire
